// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, parameter defaults and request layout
// for the divider front/back-end sequencer.
package div_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        OUT
    } state_e;

    // Request layout at the default widths; the sequencer rebuilds it at its own N/TAG_W.
    typedef struct packed {
        logic [N_DEF-1:0]     dividend;
        logic [N_DEF-1:0]     divisor;
        logic [TAG_W_DEF-1:0] tag;
    } div_req_t;

endpackage

// File: rtl/div_sequencer_fifo.sv
// sync_fifo: registered-output-free synchronous FIFO; a push becomes visible
// at the head one cycle later, and simultaneous push/pop keeps the count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices meet.
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: buffers division requests, issues them one at a time to an
// iterative divider, and returns tagged results (zero divisors handled locally).
module div_sequencer
    import div_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_dividend,
    input  logic [N-1:0]     in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_quotient,
    output logic [N-1:0]     out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             div_start,
    output logic [N-1:0]     div_dividend,
    output logic [N-1:0]     div_divisor,
    input  logic [N-1:0]     div_quotient,
    input  logic [N-1:0]     div_remainder,
    input  logic             div_ready
);

    typedef struct packed {
        logic [N-1:0]     dividend;
        logic [N-1:0]     divisor;
        logic [TAG_W-1:0] tag;
    } req_t;

    state_e           state_q, state_d;
    req_t             head;
    logic             full, empty, pop;
    logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
    logic [N-1:0]     quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;

    sync_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && !full),
        .pop   (pop),
        .din   ({in_dividend, in_divisor, in_tag}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        otag_d    = otag_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        pop       = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && head.divisor == '0) begin
                    pop     = 1'b1;
                    quot_d  = '1;
                    rem_d   = head.dividend;
                    otag_d  = head.tag;
                    dbz_d   = 1'b1;
                    state_d = OUT;
                end else if (!empty && div_ready) begin
                    pop       = 1'b1;
                    div_start = 1'b1;
                    tag_d     = head.tag;
                    state_d   = WAIT_DONE;
                end
            end
            // The divider drops ready the cycle after start, so this cannot fire early.
            WAIT_DONE: begin
                if (div_ready) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    otag_d  = tag_q;
                    dbz_d   = 1'b0;
                    state_d = OUT;
                end
            end
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            otag_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            otag_q  <= otag_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready      = !full;
    assign out_valid     = (state_q == OUT);
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_tag       = otag_q;
    assign out_dbz       = dbz_q;
    assign div_dividend  = head.dividend;
    assign div_divisor   = head.divisor;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench for div_sequencer with a behavioural
// N-cycle divider attached to its start/ready interface.
module tb_div_sequencer;

    localparam int N = 32;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, out_dbz;
    logic [N-1:0] in_dividend, in_divisor, out_quotient, out_remainder;
    logic [W-1:0] in_tag, out_tag;
    logic         div_start, div_ready;
    logic [N-1:0] div_dividend, div_divisor, dq, dr;
    int           dcnt = 0;
    int           starts = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [N-1:0] a, b, q, r;
        logic [W-1:0] t;
    } vec_t;

    vec_t bp [6];
    vec_t sp [6];
    vec_t ed [3];

    always #5 clk = ~clk;

    div_sequencer #(.N(N), .DEPTH(4), .TAG_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_dbz       (out_dbz),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (dq),
        .div_remainder (dr),
        .div_ready     (div_ready)
    );

    // Divider model: no reset, ready low for N-1 cycles after start, result at start+N.
    assign div_ready = (dcnt == 0);
    always @(posedge clk) begin
        if (div_start) begin
            dcnt <= N - 1;
            dq   <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
            dr   <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end

    always @(posedge clk) if (div_start) starts <= starts + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        in_dividend = v.a;
        in_divisor  = v.b;
        in_tag      = v.t;
        in_valid    = 1'b1;
    endtask

    task automatic push(input vec_t v);
        drive(v);
        tick();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic check_res(input string tag, input vec_t v, input logic dbz);
        check({tag, "_q"}, out_quotient, v.q);
        check({tag, "_r"}, out_remainder, v.r);
        check({tag, "_tag"}, out_tag, v.t);
        check({tag, "_dbz"}, out_dbz, dbz);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, s0;
        vec_t v;
        bp[0] = '{100, 3, 33, 1, 0};
        bp[1] = '{200, 7, 28, 4, 1};
        bp[2] = '{50, 6, 8, 2, 2};
        bp[3] = '{81, 9, 9, 0, 3};
        bp[4] = '{1000, 13, 76, 12, 4};
        bp[5] = '{7, 2, 3, 1, 5};
        sp[0] = '{40, 4, 10, 0, 6};
        sp[1] = '{45, 4, 11, 1, 7};
        sp[2] = '{99, 10, 9, 9, 8};
        sp[3] = '{17, 5, 3, 2, 9};
        sp[4] = '{64, 8, 8, 0, 10};
        sp[5] = '{1, 1, 1, 0, 11};
        ed[0] = '{32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 12};
        ed[1] = '{5, 9, 0, 5, 13};
        ed[2] = '{0, 3, 0, 0, 14};

        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_q", out_quotient, 0);
        check("rst_r", out_remainder, 0);
        check("rst_tag", out_tag, 0);
        check("rst_dbz", out_dbz, 0);
        check("rst_start", div_start, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic division and latency
        push('{100, 7, 14, 2, 3});
        check("basic_start", div_start, 1);
        wait_out(n);
        check("basic_lat", n, 33);
        check_res("basic", '{100, 7, 14, 2, 3}, 1'b0);
        tick();

        // Divide-by-zero bypasses the divider
        s0 = starts;
        push('{32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 5});
        check("dbz_start", div_start, 0);
        check("dbz_early", out_valid, 0);
        tick();
        check("dbz_lat", out_valid, 1);
        check_res("dbz", '{32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 5}, 1'b1);
        check("dbz_no_start", starts - s0, 0);
        tick();

        // Backpressure: fill FIFO, hold outputs, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(bp[i]);
            check("bp_in_ready", in_ready, 1);
            tick();
        end
        drive(bp[5]);
        check("bp_full", in_ready, 0);
        wait_out(n);
        check_res("bp_first", bp[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_q", out_quotient, bp[0].q);
            check("bp_hold_tag", out_tag, bp[0].t);
            check("bp_hold_full", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_out(n);
            check_res("bp_order", bp[k], 1'b0);
            tick();
        end

        // Reset in the middle of a division
        push('{1000, 10, 100, 0, 1});
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_q", out_quotient, 0);
        check("mid_rst_r", out_remainder, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_start", div_start, 0);
        tick();
        tick();
        rst_n = 1'b1;
        push('{9, 3, 3, 0, 2});
        check("mid_rst_hold", div_start, 0);
        n = 0;
        while (!div_start && n < 100) begin
            tick();
            n++;
        end
        check("mid_rst_issue", div_start, 1);
        check("mid_rst_issue_rdy", div_ready, 1);
        wait_out(n);
        check_res("mid_rst_res", '{9, 3, 3, 0, 2}, 1'b0);
        tick();

        // Push in the same cycle the head is issued keeps the count
        push(sp[0]);
        push(sp[1]);
        push(sp[2]);
        wait_out(n);
        check_res("sp_a", sp[0], 1'b0);
        tick();
        check("sp_issue", div_start, 1);
        for (int i = 3; i < 6; i++) begin
            drive(sp[i]);
            check("sp_in_ready", in_ready, 1);
            tick();
        end
        check("sp_full", in_ready, 0);
        for (int k = 1; k < 6; k++) begin
            wait_out(n);
            check_res("sp_order", sp[k], 1'b0);
            tick();
        end

        // Edge operands
        for (int k = 0; k < 3; k++) begin
            v = ed[k];
            push(v);
            wait_out(n);
            check_res("edge", v, 1'b0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Front-end and back-end stage for the iterative `divider` (radix-2 long division, N-cycle busy time).
- Buffers operand pairs arriving on a valid/ready stream in a small FIFO and issues them one at a time on the divider's start/ready interface.
- Collects quotient/remainder when the divider finishes and presents them, with a request tag, on an output valid/ready stream.
- Handles divide-by-zero locally without occupying the divider.

Parameters:
- N, 32, operand/result width; must equal the attached divider's N.
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the user tag carried from request to result.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_dividend  input  N  dividend.
- in_divisor  input  N  divisor.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_quotient  output  N  quotient.
- out_remainder  output  N  remainder.
- out_tag  output  TAG_W  tag of the request that produced this result.
- out_dbz  output  1  result came from a zero divisor.
- div_start  output  1  divider start pulse.
- div_dividend  output  N  operand to divider.
- div_divisor  output  N  operand to divider.
- div_quotient  input  N  divider quotient.
- div_remainder  input  N  divider remainder.
- div_ready  input  1  divider idle / result stable.

Behaviour:
- Reset, asynchronous on rst_n low:
  - FIFO is emptied.
  - FSM goes to IDLE.
  - out_valid=0; out_quotient, out_remainder, out_tag, out_dbz all 0.
  - div_start=0.
  - The divider has no reset. The sequencer never assumes div_ready=1 after reset.
- FIFO behaviour:
  - Push when in_valid && in_ready.
  - A push at cycle t is visible at the head at t+1; there is no fall-through.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - When full, in_ready=0 and in_valid is ignored.
- div_dividend and div_divisor are driven combinationally from the FIFO head at all times.
- IDLE:
  - If FIFO is empty: stay in IDLE.
  - If the head divisor is 0: pop the head. Load out_quotient={N{1}}, out_remainder=head dividend, out_tag=head tag, out_dbz=1. Go to OUT. div_start stays 0.
  - Else if div_ready=1: pop the head, assert div_start for this single cycle, latch the head tag internally, and go to WAIT_DONE.
  - Else (divider still busy, e.g. reset mid-division): stay in IDLE.
- WAIT_DONE:
  - The divider drops ready in the cycle after start. The first WAIT_DONE cycle therefore always sees div_ready=0.
  - When div_ready=1: load out_quotient=div_quotient, out_remainder=div_remainder, out_tag=latched tag, out_dbz=0. Go to OUT.
  - Latency rule: with div_start at cycle t, the capture happens at cycle t+N and out_valid is high from t+N+1.
- OUT:
  - out_valid=1.
  - All out_* fields are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE. The next issue happens no earlier than the following cycle.
- Zero-divisor path: from pop to out_valid is 1 cycle.
- Ordering: results leave in request order; the FSM holds at most one request in flight.
- Throughput: one division per N+2 cycles when out_ready is tied high; one zero-divisor result per 2 cycles.
- div_start is asserted only in IDLE and only when div_ready=1. It is never asserted twice without an intervening WAIT_DONE.
- Reset during WAIT_DONE:
  - The in-flight result is discarded.
  - The divider may still be running. IDLE waits for div_ready before the next issue.
- in_ready stays driven from FIFO state in every FSM state, so the FIFO keeps filling while a division is in progress.

Decomposition:
- Package div_pkg holds:
  - the FSM state enum {IDLE, WAIT_DONE, OUT};
  - localparams for the defaults of N, DEPTH and TAG_W;
  - a packed request struct {dividend, divisor, tag}.
- One sub-module, sync_fifo:
  - parameterised width and depth;
  - asynchronous active-low reset;
  - ports: push, pop, din, dout, full, empty.
- The FSM and output register live in div_sequencer.

Test Plan:
- Basic division: push 100/7, tag 3, with a behavioural divider model (N=32). Required: div_start exactly 1 cycle after the push, then out_valid at start+33 with q=14, r=2, tag=3, dbz=0.
- Divide-by-zero: push 0x1234/0, tag 5. Required: div_start never asserted; q=0xFFFFFFFF, r=0x1234, dbz=1; out_valid 2 cycles after the push.
- Backpressure and ordering:
  - Hold out_ready=0 and push 6 requests back-to-back.
  - Required: in_ready=0 once the FIFO holds 4 entries; outputs frozen while out_ready=0.
  - Then release out_ready. Required: results emerge in tag order 0..5 with correct quotients.
- Reset mid-operation:
  - Assert rst_n low 10 cycles into a division; the divider model keeps running.
  - Required: all outputs 0 immediately.
  - Push 9/3 after release. Required: div_start only after div_ready returns high; result q=3, r=0.
- Simultaneous push/pop: with the FIFO at 2 entries, push in the cycle the head is issued. Required: count stays 2 and no entry is lost or duplicated.
- Edge operands:
  - 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
  - 5/9 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
